// File: rtl/addsub_div_ctrl.sv
// Sequential unsigned 4-bit restoring divider built around a single shared add/subtract unit.
// A zero divisor skips the iteration loop and reports quotient=4'hF, remainder=dividend.

module addsub_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       d,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] sum;

    // With d=1 this computes b + ~a + 1 = b - a; the carry out means no borrow (b >= a).
    assign sum   = {1'b0, b} + {1'b0, a ^ {4{d}}} + {4'b0000, d};
    assign s     = sum[3:0];
    assign c_out = sum[4];
endmodule

module addsub_div_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t     state_q;
    logic [3:0] r_q;
    logic [3:0] q_q;
    logic [3:0] dv_q;
    logic [1:0] cnt_q;

    logic       m;
    logic [3:0] rs;
    logic [3:0] diff;
    logic       no_borrow;
    logic       ok;
    logic [3:0] r_next;
    logic [3:0] q_next;

    // m is the bit shifted out of R; when set, the true partial remainder is >= 16 > Dv,
    // so the 4-bit wrapped difference is still the correct new remainder.
    assign m      = r_q[3];
    assign rs     = {r_q[2:0], q_q[3]};
    assign ok     = m | no_borrow;
    assign r_next = ok ? diff : rs;
    assign q_next = {q_q[2:0], ok};
    assign busy   = (state_q != StIdle);

    addsub_4bit u_addsub (
        .a     (dv_q),
        .b     (rs),
        .d     (1'b1),
        .s     (diff),
        .c_out (no_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            r_q         <= 4'd0;
            q_q         <= 4'd0;
            dv_q        <= 4'd0;
            cnt_q       <= 2'd0;
            done        <= 1'b0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor != 4'd0) begin
                            r_q     <= 4'd0;
                            q_q     <= dividend;
                            dv_q    <= divisor;
                            cnt_q   <= 2'd0;
                            state_q <= StRun;
                        end else begin
                            quotient    <= 4'hF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StRun: begin
                    r_q   <= r_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Directed bench for addsub_div_ctrl: latency, corner quotients, divide-by-zero,
// start-while-busy, mid-run reset and an exhaustive sweep with start held high.

module tb_addsub_div_ctrl;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks;
    int failures;
    int cyc;

    addsub_div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (edge N); lat = k where done is first seen high after edge N+k.
    task automatic run_div(input logic [3:0] dd, input logic [3:0] dv, output int lat);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        if (done) lat = 0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] eq, input logic [3:0] er,
                                input logic ez);
        check({tag, "_q"}, int'(quotient), int'(eq));
        check({tag, "_r"}, int'(remainder), int'(er));
        check({tag, "_z"}, int'(div_by_zero), int'(ez));
    endtask

    initial begin
        int lat;
        int pulses;
        int last;
        int got;
        logic [7:0] v;
        logic [3:0] eq;
        logic [3:0] er;
        logic       ez;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_res", int'({quotient, remainder, div_by_zero}), 0);
        @(negedge clk);
        rst = 1'b0;

        // 13/4 with busy and exact latency
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("lat_busy_n", int'(busy), 1);
        check("lat_done_n", int'(done), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lat_done_early", int'(done), 0);
            check("lat_busy_run", int'(busy), 1);
        end
        @(negedge clk);
        check("lat_done_n4", int'(done), 1);
        check_result("d13_4", 4'd3, 4'd1, 1'b0);
        @(negedge clk);
        check("lat_done_n5", int'(done), 0);

        run_div(4'd15, 4'd1, lat);
        check("d15_1_lat", lat, 4);
        check_result("d15_1", 4'd15, 4'd0, 1'b0);
        run_div(4'd15, 4'd15, lat);
        check_result("d15_15", 4'd1, 4'd0, 1'b0);
        run_div(4'd7, 4'd9, lat);
        check_result("d7_9", 4'd0, 4'd7, 1'b0);
        run_div(4'd0, 4'd5, lat);
        check_result("d0_5", 4'd0, 4'd0, 1'b0);

        run_div(4'd9, 4'd0, lat);
        check("dz_lat_ok", int'(lat >= 0 && lat <= 1), 1);
        check_result("d9_0", 4'hF, 4'd9, 1'b1);
        run_div(4'd8, 4'd3, lat);
        check("d8_3_lat", lat, 4);
        check_result("d8_3", 4'd2, 4'd2, 1'b0);

        // 14/3 with a 1/1 start pulse at edge N+2 that must be ignored
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                dividend = 4'd1;
                divisor  = 4'd1;
                start    = 1'b1;
            end else if (k == 2) begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                check_result("d14_3", 4'd4, 4'd2, 1'b0);
            end
        end
        check("busy_ignore_pulses", pulses, 1);

        // 12/5 aborted by reset after edge N+2
        @(negedge clk);
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_res", int'({quotient, remainder, div_by_zero}), 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        rst = 1'b0;
        run_div(4'd12, 4'd5, lat);
        check("d12_5_lat", lat, 4);
        check_result("d12_5", 4'd2, 4'd2, 1'b0);

        // Exhaustive sweep, start held high
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        last  = -1;
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            dividend = v[7:4];
            divisor  = v[3:0];
            if (v[3:0] == 4'd0) begin
                eq = 4'hF;
                er = v[7:4];
                ez = 1'b1;
            end else begin
                eq = v[7:4] / v[3:0];
                er = v[7:4] % v[3:0];
                ez = 1'b0;
            end
            got = 0;
            for (int k = 0; k < 12 && got == 0; k++) begin
                @(negedge clk);
                if (done) got = 1;
            end
            check("ex_done", got, 1);
            check("ex_res", int'({quotient, remainder, div_by_zero}), int'({eq, er, ez}));
            if (v[3:0] != 4'd0 && last >= 0) check("ex_gap", cyc - last, 6);
            last = cyc;
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
